// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the unified-memory arbiter.
// Owner encoding is used both for the round-robin pointer and the read-return tag.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
   localparam int STREAK_W   = 4;

   localparam logic OWNER_I = 1'b0;
   localparam logic OWNER_D = 1'b1;

   typedef struct packed {
      logic valid;
      logic owner;
   } rd_tag_t;

endpackage

// File: rtl/mem_arb_rdret.sv
// Read-return path: remembers who issued last cycle's read and steers the
// memory's one-cycle-latency data to that requester, holding it afterwards.
module mem_arb_rdret
   import mem_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_issue,
   input  logic                   i_owner,
   input  logic [DATA_W-1:0]      i_m_r_data,
   output logic [1:0]             o_r_valid,
   output logic [1:0][DATA_W-1:0] o_r_data
);

   rd_tag_t                r_tag;
   logic [1:0][DATA_W-1:0] r_hold;
   logic [1:0]             w_ret;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tag  <= '0;
         r_hold <= '0;
      end else begin
         r_tag <= '{valid: i_issue, owner: i_owner};
         for (int k = 0; k < 2; k++) begin
            if (w_ret[k]) begin
               r_hold[k] <= i_m_r_data;
            end
         end
      end
   end

   // While reset is high a tag left over from the previous cycle must not
   // produce a return, and the visible data is forced to zero.
   for (genvar gi = 0; gi < 2; gi++) begin : g_owner
      assign w_ret[gi]     = r_tag.valid & (r_tag.owner == 1'(gi)) & ~rst;
      assign o_r_valid[gi] = w_ret[gi];
      assign o_r_data[gi]  = rst ? '0 : (w_ret[gi] ? i_m_r_data : r_hold[gi]);
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the core's instruction and data buses onto one memory instance.
// Grant is combinational in the request cycle; read data returns one cycle later.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int DATA_PRIO  = 1,
   parameter int MAX_STREAK = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_r_en,
   input  logic [ADDR_W-1:0] i_r_addr,
   input  logic              i_w_en,
   input  logic [ADDR_W-1:0] i_w_addr,
   input  logic [DATA_W-1:0] i_w_data,
   output logic              i_gnt,
   output logic              i_r_valid,
   output logic [DATA_W-1:0] i_r_data,
   input  logic              d_r_en,
   input  logic [ADDR_W-1:0] d_r_addr,
   input  logic              d_w_en,
   input  logic [ADDR_W-1:0] d_w_addr,
   input  logic [DATA_W-1:0] d_w_data,
   output logic              d_gnt,
   output logic              d_r_valid,
   output logic [DATA_W-1:0] d_r_data,
   output logic              m_r_en,
   output logic [ADDR_W-1:0] m_r_addr,
   input  logic [DATA_W-1:0] m_r_data,
   output logic              m_w_en,
   output logic [ADDR_W-1:0] m_w_addr,
   output logic [DATA_W-1:0] m_w_data
);

   logic                   w_i_req;
   logic                   w_d_req;
   logic                   w_contest;
   logic                   w_i_gnt;
   logic                   w_d_gnt;
   logic                   r_rr_ptr;
   logic                   w_rr_ptr_next;
   logic [STREAK_W-1:0]    r_streak;
   logic [STREAK_W-1:0]    w_streak_next;
   logic [1:0]             w_rd_valid;
   logic [1:0][DATA_W-1:0] w_rd_data;

   assign w_i_req   = i_r_en | i_w_en;
   assign w_d_req   = d_r_en | d_w_en;
   assign w_contest = w_i_req & w_d_req;

   always_comb begin : arb
      w_i_gnt = 1'b0;
      w_d_gnt = 1'b0;
      if (!rst) begin
         if (w_contest) begin
            if (DATA_PRIO != 0) begin
               if (r_streak < STREAK_W'(MAX_STREAK)) begin
                  w_d_gnt = 1'b1;
               end else begin
                  w_i_gnt = 1'b1;
               end
            end else if (r_rr_ptr == OWNER_D) begin
               w_d_gnt = 1'b1;
            end else begin
               w_i_gnt = 1'b1;
            end
         end else begin
            w_i_gnt = w_i_req;
            w_d_gnt = w_d_req;
         end
      end
   end

   // Pointer moves to the loser only on contested grants; uncontested data
   // grants leave the streak alone, any instruction grant clears it.
   always_comb begin : policy_next
      w_rr_ptr_next = r_rr_ptr;
      w_streak_next = r_streak;
      if (w_contest && w_d_gnt) begin
         w_rr_ptr_next = OWNER_I;
         if (DATA_PRIO != 0) begin
            w_streak_next = r_streak + STREAK_W'(1);
         end
      end
      if (w_contest && w_i_gnt) begin
         w_rr_ptr_next = OWNER_D;
      end
      if (w_i_gnt) begin
         w_streak_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr <= OWNER_I;
         r_streak <= '0;
      end else begin
         r_rr_ptr <= w_rr_ptr_next;
         r_streak <= w_streak_next;
      end
   end

   always_comb begin : mem_mux
      m_r_en   = 1'b0;
      m_r_addr = '0;
      m_w_en   = 1'b0;
      m_w_addr = '0;
      m_w_data = '0;
      if (w_d_gnt) begin
         m_r_en   = d_r_en;
         m_r_addr = d_r_addr;
         m_w_en   = d_w_en;
         m_w_addr = d_w_addr;
         m_w_data = d_w_data;
      end else if (w_i_gnt) begin
         m_r_en   = i_r_en;
         m_r_addr = i_r_addr;
         m_w_en   = i_w_en;
         m_w_addr = i_w_addr;
         m_w_data = i_w_data;
      end
   end

   mem_arb_rdret #(
      .DATA_W (DATA_W)
   ) u_rdret (
      .clk        (clk),
      .rst        (rst),
      .i_issue    (m_r_en),
      .i_owner    (w_d_gnt ? OWNER_D : OWNER_I),
      .i_m_r_data (m_r_data),
      .o_r_valid  (w_rd_valid),
      .o_r_data   (w_rd_data)
   );

   assign i_gnt     = w_i_gnt;
   assign d_gnt     = w_d_gnt;
   assign i_r_valid = w_rd_valid[OWNER_I];
   assign i_r_data  = w_rd_data[OWNER_I];
   assign d_r_valid = w_rd_valid[OWNER_D];
   assign d_r_data  = w_rd_data[OWNER_D];

endmodule

// File: tb/tb_mem_arbiter.sv
// Two arbiters (data-priority and round-robin) each in front of a small memory,
// checked against a cycle-level behavioural model plus directed tables.
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int MAX_STREAK = 4;

   typedef struct packed {
      logic        r_en;
      logic [31:0] r_addr;
      logic        w_en;
      logic [31:0] w_addr;
      logic [31:0] w_data;
   } req_t;

   // ef = {dut0 i_gnt, dut0 d_gnt, dut1 i_gnt, dut1 d_gnt, m_r_en, m_w_en, i_r_valid, d_r_valid}
   typedef struct {
      logic        rst;
      req_t        ir;
      req_t        dr;
      logic [7:0]  ef;
      logic [31:0] ird;
      logic [31:0] drd;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   req_t [1:0] ireq = '0;
   req_t [1:0] dreq = '0;
   logic [1:0] o_ig, o_dg, o_irv, o_drv, o_mre, o_mwe;
   logic [1:0][31:0] o_ird, o_drd, o_mra, o_mwa, o_mwd, o_mrd;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(int j);
      return (j == 4) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(j);
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      logic [31:0] mem_q [0:63];
      logic [63:0] wr_flag = 64'd0;
      logic [31:0] rd_q = 32'd0;

      mem_arbiter #(
         .ADDR_W(32), .DATA_W(32), .DATA_PRIO(gi == 0 ? 1 : 0), .MAX_STREAK(MAX_STREAK)
      ) u_dut (
         .clk(clk), .rst(rst),
         .i_r_en(ireq[gi].r_en), .i_r_addr(ireq[gi].r_addr), .i_w_en(ireq[gi].w_en),
         .i_w_addr(ireq[gi].w_addr), .i_w_data(ireq[gi].w_data),
         .i_gnt(o_ig[gi]), .i_r_valid(o_irv[gi]), .i_r_data(o_ird[gi]),
         .d_r_en(dreq[gi].r_en), .d_r_addr(dreq[gi].r_addr), .d_w_en(dreq[gi].w_en),
         .d_w_addr(dreq[gi].w_addr), .d_w_data(dreq[gi].w_data),
         .d_gnt(o_dg[gi]), .d_r_valid(o_drv[gi]), .d_r_data(o_drd[gi]),
         .m_r_en(o_mre[gi]), .m_r_addr(o_mra[gi]), .m_r_data(rd_q),
         .m_w_en(o_mwe[gi]), .m_w_addr(o_mwa[gi]), .m_w_data(o_mwd[gi])
      );

      // Memory with one-cycle read latency; read returns the pre-write contents.
      always @(posedge clk) begin
         if (o_mre[gi]) rd_q <= wr_flag[o_mra[gi][7:2]] ? mem_q[o_mra[gi][7:2]] : init_word(int'(o_mra[gi][7:2]));
         if (o_mwe[gi]) begin
            mem_q[o_mwa[gi][7:2]]   <= o_mwd[gi];
            wr_flag[o_mwa[gi][7:2]] <= 1'b1;
         end
      end
      assign o_mrd[gi] = rd_q;
   end

   // Reference model state, one set per arbiter (0 = data priority, 1 = round robin).
   logic [31:0] mmem [2][64];
   int          streak [2];
   logic        rr_i [2];
   logic        pv [2], pown [2];
   logic [31:0] pdata [2], hold_i [2], hold_d [2];
   logic        eg_i [2], eg_d [2];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chkb(string nm, logic act, logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", nm, act, exp);
      end
   endtask

   function automatic req_t rq(logic r, logic [31:0] ra, logic w, logic [31:0] wa, logic [31:0] wd);
      req_t q;
      q.r_en = r; q.r_addr = ra; q.w_en = w; q.w_addr = wa; q.w_data = wd;
      return q;
   endfunction

   function automatic req_t rand_req();
      req_t q;
      q = '0;
      if ($urandom_range(0, 9) >= 3) begin
         q.r_en   = 1'($urandom_range(0, 1));
         q.w_en   = 1'($urandom_range(0, 1));
         q.r_addr = 32'($urandom_range(0, 63)) << 2;
         q.w_addr = 32'($urandom_range(0, 63)) << 2;
         q.w_data = $urandom;
      end
      return q;
   endfunction

   task automatic model_check();
      for (int k = 0; k < 2; k++) begin
         logic ri, rd, any;
         req_t w;
         logic [31:0] e_ird, e_drd;
         ri = ireq[k].r_en | ireq[k].w_en;
         rd = dreq[k].r_en | dreq[k].w_en;
         if (rst) begin
            eg_i[k] = 1'b0; eg_d[k] = 1'b0;
         end else if (ri && rd) begin
            eg_d[k] = (k == 0) ? (streak[k] < MAX_STREAK) : !rr_i[k];
            eg_i[k] = !eg_d[k];
         end else begin
            eg_i[k] = ri; eg_d[k] = rd;
         end
         any = eg_i[k] | eg_d[k];
         w = eg_d[k] ? dreq[k] : ireq[k];
         e_ird = rst ? 32'd0 : ((pv[k] && !pown[k]) ? pdata[k] : hold_i[k]);
         e_drd = rst ? 32'd0 : ((pv[k] &&  pown[k]) ? pdata[k] : hold_d[k]);
         chkb($sformatf("model dut%0d i_gnt", k), o_ig[k], eg_i[k]);
         chkb($sformatf("model dut%0d d_gnt", k), o_dg[k], eg_d[k]);
         chkb($sformatf("model dut%0d m_r_en", k), o_mre[k], any & w.r_en);
         chk($sformatf("model dut%0d m_r_addr", k), o_mra[k], any ? w.r_addr : 32'd0);
         chkb($sformatf("model dut%0d m_w_en", k), o_mwe[k], any & w.w_en);
         chk($sformatf("model dut%0d m_w_addr", k), o_mwa[k], any ? w.w_addr : 32'd0);
         chk($sformatf("model dut%0d m_w_data", k), o_mwd[k], any ? w.w_data : 32'd0);
         chkb($sformatf("model dut%0d i_r_valid", k), o_irv[k], !rst && pv[k] && !pown[k]);
         chkb($sformatf("model dut%0d d_r_valid", k), o_drv[k], !rst && pv[k] && pown[k]);
         chk($sformatf("model dut%0d i_r_data", k), o_ird[k], e_ird);
         chk($sformatf("model dut%0d d_r_data", k), o_drd[k], e_drd);
      end
   endtask

   task automatic model_update();
      for (int k = 0; k < 2; k++) begin
         logic any, contested;
         req_t w;
         if (rst) begin
            streak[k] = 0; rr_i[k] = 1'b1; pv[k] = 1'b0; hold_i[k] = '0; hold_d[k] = '0;
         end else begin
            any = eg_i[k] | eg_d[k];
            w = eg_d[k] ? dreq[k] : ireq[k];
            contested = (ireq[k].r_en | ireq[k].w_en) & (dreq[k].r_en | dreq[k].w_en);
            if (pv[k]) begin
               if (pown[k]) hold_d[k] = pdata[k];
               else         hold_i[k] = pdata[k];
            end
            pv[k]    = any & w.r_en;
            pown[k]  = eg_d[k];
            pdata[k] = mmem[k][w.r_addr[7:2]];
            if (any && w.w_en) mmem[k][w.w_addr[7:2]] = w.w_data;
            if (contested) begin
               if (k == 0) begin
                  if (eg_d[k]) streak[k]++;
               end else begin
                  rr_i[k] = eg_d[k];
               end
            end
            if (eg_i[k]) streak[k] = 0;
         end
      end
   endtask

   task automatic cyc_check();
      @(negedge clk);
      model_check();
   endtask

   task automatic cyc_end();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic drive_both(req_t ir, req_t dr);
      for (int k = 0; k < 2; k++) begin
         ireq[k] = ir;
         dreq[k] = dr;
      end
   endtask

   vec_t tbl [11];
   logic [9:0] pat0;

   initial begin
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 64; j++) mmem[k][j] = init_word(j);
         streak[k] = 0; rr_i[k] = 1'b1; pv[k] = 1'b0; pown[k] = 1'b0;
         pdata[k] = '0; hold_i[k] = '0; hold_d[k] = '0; eg_i[k] = 1'b0; eg_d[k] = 1'b0;
      end

      tbl[0]  = '{1'b1, rq(1'b1, 32'h10, 1'b0, 32'h0, 32'h0), rq(1'b1, 32'h0, 1'b0, 32'h0, 32'h0), 8'b0000_0000, 32'h0, 32'h0};
      tbl[1]  = '{1'b0, rq(1'b1, 32'h10, 1'b0, 32'h0, 32'h0), '0, 8'b1010_1000, 32'h0, 32'h0};
      tbl[2]  = '{1'b0, '0, '0, 8'b0000_0010, 32'hDEAD_BEEF, 32'h0};
      tbl[3]  = '{1'b0, '0, '0, 8'b0000_0000, 32'hDEAD_BEEF, 32'h0};
      tbl[4]  = '{1'b0, rq(1'b1, 32'h20, 1'b0, 32'h0, 32'h0), rq(1'b0, 32'h0, 1'b1, 32'h20, 32'h1234_5678), 8'b0110_0100, 32'hDEAD_BEEF, 32'h0};
      tbl[5]  = '{1'b0, rq(1'b1, 32'h20, 1'b0, 32'h0, 32'h0), '0, 8'b1010_1000, 32'hDEAD_BEEF, 32'h0};
      tbl[6]  = '{1'b0, '0, '0, 8'b0000_0010, 32'h1234_5678, 32'h0};
      tbl[7]  = '{1'b0, '0, rq(1'b1, 32'h4, 1'b1, 32'h8, 32'hA5), 8'b0101_1100, 32'h1234_5678, 32'h0};
      tbl[8]  = '{1'b0, '0, '0, 8'b0000_0001, 32'h1234_5678, 32'h1000_0001};
      tbl[9]  = '{1'b0, '0, rq(1'b1, 32'h8, 1'b0, 32'h0, 32'h0), 8'b0101_1000, 32'h1234_5678, 32'h1000_0001};
      tbl[10] = '{1'b0, '0, '0, 8'b0000_0001, 32'h1234_5678, 32'hA5};

      // Initial reset
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         cyc_check();
         cyc_end();
      end

      // Directed table
      for (int r = 0; r < 11; r++) begin
         rst = tbl[r].rst;
         drive_both(tbl[r].ir, tbl[r].dr);
         cyc_check();
         chkb($sformatf("tbl%0d dut0 i_gnt", r), o_ig[0], tbl[r].ef[7]);
         chkb($sformatf("tbl%0d dut0 d_gnt", r), o_dg[0], tbl[r].ef[6]);
         chkb($sformatf("tbl%0d dut1 i_gnt", r), o_ig[1], tbl[r].ef[5]);
         chkb($sformatf("tbl%0d dut1 d_gnt", r), o_dg[1], tbl[r].ef[4]);
         chkb($sformatf("tbl%0d dut0 m_r_en", r), o_mre[0], tbl[r].ef[3]);
         chkb($sformatf("tbl%0d dut0 m_w_en", r), o_mwe[0], tbl[r].ef[2]);
         chkb($sformatf("tbl%0d dut0 i_r_valid", r), o_irv[0], tbl[r].ef[1]);
         chkb($sformatf("tbl%0d dut0 d_r_valid", r), o_drv[0], tbl[r].ef[0]);
         chk($sformatf("tbl%0d dut0 i_r_data", r), o_ird[0], tbl[r].ird);
         chk($sformatf("tbl%0d dut0 d_r_data", r), o_drd[0], tbl[r].drd);
         cyc_end();
      end

      // Both buses read every cycle: streak pattern on dut0, alternation on dut1
      rst = 1'b1;
      drive_both('0, '0);
      cyc_check();
      cyc_end();
      rst = 1'b0;
      drive_both(rq(1'b1, 32'h10, 1'b0, 32'h0, 32'h0), rq(1'b1, 32'h14, 1'b0, 32'h0, 32'h0));
      pat0 = 10'b11110_11110;
      for (int c = 0; c < 10; c++) begin
         cyc_check();
         chkb($sformatf("streak c%0d dut0 d_gnt", c), o_dg[0], pat0[9-c]);
         chkb($sformatf("rr c%0d dut1 i_gnt", c), o_ig[1], (c % 2) == 0);
         if (c > 0) chkb($sformatf("streak c%0d dut0 d_r_valid", c), o_drv[0], pat0[10-c]);
         cyc_end();
      end

      // Read granted, then reset in the following cycle
      drive_both(rq(1'b1, 32'h10, 1'b0, 32'h0, 32'h0), '0);
      cyc_check();
      chkb("rstseq dut0 i_gnt", o_ig[0], 1'b1);
      cyc_end();
      rst = 1'b1;
      drive_both(rq(1'b1, 32'h10, 1'b0, 32'h0, 32'h0), rq(1'b1, 32'h14, 1'b0, 32'h0, 32'h0));
      cyc_check();
      for (int k = 0; k < 2; k++) begin
         chkb($sformatf("rstseq dut%0d i_gnt", k), o_ig[k], 1'b0);
         chkb($sformatf("rstseq dut%0d d_gnt", k), o_dg[k], 1'b0);
         chkb($sformatf("rstseq dut%0d i_r_valid", k), o_irv[k], 1'b0);
         chkb($sformatf("rstseq dut%0d d_r_valid", k), o_drv[k], 1'b0);
         chkb($sformatf("rstseq dut%0d m_r_en", k), o_mre[k], 1'b0);
         chk($sformatf("rstseq dut%0d i_r_data", k), o_ird[k], 32'h0);
         chk($sformatf("rstseq dut%0d m_r_addr", k), o_mra[k], 32'h0);
      end
      cyc_end();
      rst = 1'b0;
      cyc_check();
      chkb("rstseq post dut0 d_gnt", o_dg[0], 1'b1);
      chkb("rstseq post dut1 i_gnt", o_ig[1], 1'b1);
      cyc_end();

      // Randomized traffic; each requester holds its request until granted
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < 2; k++) begin
            if (eg_i[k] || !(ireq[k].r_en | ireq[k].w_en)) ireq[k] = rand_req();
            if (eg_d[k] || !(dreq[k].r_en | dreq[k].w_en)) dreq[k] = rand_req();
         end
         rst = ($urandom_range(0, 99) == 0);
         cyc_check();
         cyc_end();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
